// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache with a two-state refill FSM
module icache #(
  parameter int LINE_CNT = 64,
  parameter int IDX_W    = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_addr,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int TAG_W = 32 - IDX_W - 2;
  typedef enum logic {IDLE, MISS} state_t;
  state_t state, state_nxt;
  logic [LINE_CNT-1:0] valid;
  logic [TAG_W-1:0] tags [LINE_CNT];
  logic [31:0] data [LINE_CNT];
  logic discard;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic hit, miss, fill, write;
  logic addr_unused;
  assign addr_unused = ^fetch_addr[1:0];
  assign idx = fetch_addr[IDX_W+1:2];
  assign tag = fetch_addr[31:IDX_W+2];
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign fill_tag = mem_addr[31:IDX_W+2];
  assign hit = state == IDLE && rdy_in && fetch_valid && valid[idx] && tags[idx] == tag;
  assign miss = state == IDLE && rdy_in && fetch_valid && !hit;
  assign fill = state == MISS && rdy_in && mem_done;
  assign write = fill && !discard && !flush_in;
  assign inst_valid = hit && !flush_in;
  assign inst_out = inst_valid ? data[idx] : '0;
  assign mem_req = state == MISS;
  always_comb state_nxt = miss ? MISS : fill ? IDLE : state;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      valid    <= '0;
      discard  <= 1'b0;
      mem_addr <= '0;
    end else begin
      if (miss) mem_addr <= {fetch_addr[31:2], 2'b00};
      if (rdy_in && state == MISS) discard <= !mem_done && (discard || flush_in);
      if (rdy_in && flush_in) valid <= '0;
      else if (write) valid[fill_idx] <= 1'b1;
    end
  always_ff @(posedge clk_in)
    if (write) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem_data;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: table-driven cycle vectors plus an async-reset sequence for icache
module tb_icache;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in, fetch_valid, mem_done;
  logic [31:0] fetch_addr, mem_data;
  logic inst_valid, mem_req;
  logic [31:0] inst_out, mem_addr;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rdy, flush, fv;
    logic [31:0] addr;
    logic done;
    logic [31:0] data;
    logic iv;
    logic [31:0] out;
    logic req;
    logic [31:0] maddr;
  } vec_t;
  vec_t vecs[$];
  icache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .inst_valid(inst_valid),
    .inst_out(inst_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic rdy, input logic flush, input logic fv, input logic [31:0] addr,
                     input logic done, input logic [31:0] data, input logic iv,
                     input logic [31:0] out, input logic req, input logic [31:0] maddr);
    vec_t v;
    v = '{rdy, flush, fv, addr, done, data, iv, out, req, maddr};
    vecs.push_back(v);
  endtask
  task automatic drive(input logic rdy, input logic flush, input logic fv, input logic [31:0] addr,
                       input logic done, input logic [31:0] data);
    rdy_in = rdy;
    flush_in = flush;
    fetch_valid = fv;
    fetch_addr = addr;
    mem_done = done;
    mem_data = data;
  endtask
  initial begin
    // cold miss, memory latency 3
    add(1,0,1,'h1004,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,0,1,'h1004,0,0,0,0,1,'h1004);
    add(1,0,1,'h1004,1,'h00A00093,0,0,1,'h1004);
    add(1,0,1,'h1004,0,0,1,'h00A00093,0,'h1004);
    // conflict on index 1
    add(1,0,1,'h1104,0,0,0,0,0,'h1004);
    add(1,0,1,'h1104,0,0,0,0,1,'h1104);
    add(1,0,1,'h1104,1,'h11111111,0,0,1,'h1104);
    add(1,0,1,'h1104,0,0,1,'h11111111,0,'h1104);
    add(1,0,1,'h1004,0,0,0,0,0,'h1104);
    add(1,0,1,'h1004,0,0,0,0,1,'h1004);
    add(1,0,1,'h1004,1,'h00A00093,0,0,1,'h1004);
    add(1,0,1,'h1004,0,0,1,'h00A00093,0,'h1004);
    // flush during miss discards the refill
    add(1,0,1,'h10,0,0,0,0,0,'h1004);
    add(1,1,1,'h10,0,0,0,0,1,'h10);
    add(1,0,1,'h10,1,'hDEADBEEF,0,0,1,'h10);
    add(1,0,1,'h10,0,0,0,0,0,'h10);
    add(1,0,1,'h10,0,0,0,0,1,'h10);
    add(1,0,1,'h10,1,'h13,0,0,1,'h10);
    add(1,0,1,'h10,0,0,1,'h13,0,'h10);
    // flush on a hit cycle suppresses inst_valid and invalidates
    add(1,1,1,'h10,0,0,0,0,0,'h10);
    add(1,0,1,'h10,0,0,0,0,0,'h10);
    add(1,0,1,'h10,0,0,0,0,1,'h10);
    // freeze in MISS with mem_done while frozen
    for (int i = 0; i < 5; i++) add(0,0,1,'h10,i == 2,'hBAD0BAD0,0,0,1,'h10);
    add(1,0,1,'h10,0,0,0,0,1,'h10);
    add(1,0,1,'h10,1,'h33,0,0,1,'h10);
    add(1,0,1,'h10,0,0,1,'h33,0,'h10);
    // flush and mem_done in the same cycle
    add(1,0,1,'h20,0,0,0,0,0,'h10);
    add(1,0,1,'h20,0,0,0,0,1,'h20);
    add(1,1,1,'h20,1,'h77,0,0,1,'h20);
    add(1,0,1,'h20,0,0,0,0,0,'h20);
    add(1,0,1,'h20,1,'h55,0,0,1,'h20);
    add(1,0,1,'h20,0,0,1,'h55,0,'h20);
    // mem_done in IDLE is ignored
    add(1,0,0,'h20,1,'h99,0,0,0,'h20);
    add(1,0,1,'h20,0,0,1,'h55,0,'h20);
    // address changes during MISS
    add(1,0,1,'h40,0,0,0,0,0,'h20);
    add(1,0,1,'h80,0,0,0,0,1,'h40);
    add(1,0,1,'h80,1,'hAB,0,0,1,'h40);
    add(1,0,1,'h80,0,0,0,0,0,'h40);
    add(1,0,1,'h80,1,'hCD,0,0,1,'h80);
    add(1,0,1,'h40,0,0,1,'hAB,0,'h80);
    add(1,0,1,'h80,0,0,1,'hCD,0,'h80);
    // top of address space, byte offset ignored, full-tag compare
    add(1,0,1,'hFFFFFFFC,0,0,0,0,0,'h80);
    add(1,0,1,'hFFFFFFFC,1,'hEE,0,0,1,'hFFFFFFFC);
    add(1,0,1,'hFFFFFFFF,0,0,1,'hEE,0,'hFFFFFFFC);
    add(1,0,1,'hFC,0,0,0,0,0,'hFFFFFFFC);
    add(1,0,1,'hFC,1,'h01,0,0,1,'hFC);
    add(1,0,1,'hFC,0,0,1,'h01,0,'hFC);
    // rdy low blocks a hit
    add(0,0,1,'hFC,0,0,0,0,0,'hFC);
    add(1,0,1,'hFC,0,0,1,'h01,0,'hFC);

    rst_in = 1'b0;
    drive(1, 0, 1, 'h1004, 0, 'h12345678);
    @(negedge clk_in);
    chk("reset inst_valid", 32'(inst_valid), 0);
    chk("reset inst_out", inst_out, 0);
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset mem_addr", mem_addr, 0);
    drive(1, 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].flush, vecs[i].fv, vecs[i].addr, vecs[i].done, vecs[i].data);
      @(negedge clk_in);
      chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].iv));
      chk($sformatf("v%0d inst_out", i), inst_out, vecs[i].out);
      chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
      @(posedge clk_in);
      #1;
    end

    // async reset while in MISS
    drive(1, 0, 1, 'h200, 0, 0);
    @(negedge clk_in);
    chk("ar idle mem_req", 32'(mem_req), 0);
    @(posedge clk_in);
    #1;
    chk("ar miss mem_req", 32'(mem_req), 1);
    chk("ar miss mem_addr", mem_addr, 'h200);
    #2;
    rst_in = 1'b0;
    #1;
    chk("ar drop mem_req", 32'(mem_req), 0);
    chk("ar drop mem_addr", mem_addr, 0);
    chk("ar drop inst_valid", 32'(inst_valid), 0);
    @(posedge clk_in);
    #1;
    chk("ar held mem_req", 32'(mem_req), 0);
    rst_in = 1'b1;
    drive(1, 0, 1, 'hFC, 0, 0);
    #1;
    chk("ar release miss", 32'(inst_valid), 0);
    @(posedge clk_in);
    #1;
    chk("ar refetch mem_req", 32'(mem_req), 1);
    chk("ar refetch mem_addr", mem_addr, 'hFC);
    drive(1, 0, 1, 'hFC, 1, 'h0BADF00D);
    @(posedge clk_in);
    #1;
    drive(1, 0, 1, 'hFC, 0, 0);
    @(negedge clk_in);
    chk("ar refill inst_valid", 32'(inst_valid), 1);
    chk("ar refill inst_out", inst_out, 'h0BADF00D);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
